mem_arbiter: RTL

- Two-master round-robin arbiter that shares the single-port instruction/data memory between requesters, e.g. the core's instruction fetch port and LSU port.
- Presents the memory's req/gnt/rvalid protocol unchanged to each master.
- The memory returns combinational rdata with rvalid one cycle after gnt. The arbiter therefore captures rdata in the grant cycle and routes the registered response to the master that owns it.
- Also reports contention (stall count) and protocol mismatches.

---
 rtl/mem_arbiter.sv | 119 +++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter in front of a single-port memory with
// combinational read data; responses are registered and routed to the owner.
module mem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req_i,
    output logic          m0_gnt_o,
    output logic          m0_rvalid_o,
    input  logic [AW-1:0] m0_addr_i,
    input  logic          m0_we_i,
    input  logic [DW-1:0] m0_wdata_i,
    output logic [DW-1:0] m0_rdata_o,
    input  logic          m1_req_i,
    output logic          m1_gnt_o,
    output logic          m1_rvalid_o,
    input  logic [AW-1:0] m1_addr_i,
    input  logic          m1_we_i,
    input  logic [DW-1:0] m1_wdata_i,
    output logic [DW-1:0] m1_rdata_o,
    output logic          mem_req_o,
    input  logic          mem_gnt_i,
    input  logic          mem_rvalid_i,
    output logic [AW-1:0] mem_addr_o,
    output logic          mem_we_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i,
    output logic [CW-1:0] stall_cnt_o,
    output logic          proto_err_o
);

    logic          prio_q,  prio_d;
    logic          pend_q,  pend_d;
    logic          owner_q, owner_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [CW-1:0] stall_q, stall_d;
    logic          err_q,   err_d;

    logic any_req;
    logic winner;
    logic gnt0, gnt1, grant;
    logic stalled;

    // With both requesting, prio_q decides; otherwise the lone requester wins.
    always_comb begin
        any_req = m0_req_i | m1_req_i;
        winner  = (m0_req_i & m1_req_i) ? prio_q : m1_req_i;
        gnt0    = mem_gnt_i & m0_req_i & ~winner;
        gnt1    = mem_gnt_i & m1_req_i & winner;
        grant   = gnt0 | gnt1;
        stalled = (m0_req_i & ~gnt0) | (m1_req_i & ~gnt1);
    end

    always_comb begin
        mem_addr_o  = '0;
        mem_we_o    = 1'b0;
        mem_wdata_o = '0;
        if (any_req) begin
            if (winner) begin
                mem_addr_o  = m1_addr_i;
                mem_we_o    = m1_we_i;
                mem_wdata_o = m1_wdata_i;
            end else begin
                mem_addr_o  = m0_addr_i;
                mem_we_o    = m0_we_i;
                mem_wdata_o = m0_wdata_i;
            end
        end
    end

    always_comb begin
        pend_d  = grant;
        owner_d = owner_q;
        rdata_d = rdata_q;
        prio_d  = prio_q;
        stall_d = stall_q;
        err_d   = err_q | (mem_rvalid_i != pend_q);
        if (grant) begin
            owner_d = winner;
            rdata_d = mem_rdata_i;
            prio_d  = ~winner;
        end
        if (stalled && (stall_q != '1)) begin
            stall_d = stall_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q  <= 1'b0;
            pend_q  <= 1'b0;
            owner_q <= 1'b0;
            rdata_q <= '0;
            stall_q <= '0;
            err_q   <= 1'b0;
        end else begin
            prio_q  <= prio_d;
            pend_q  <= pend_d;
            owner_q <= owner_d;
            rdata_q <= rdata_d;
            stall_q <= stall_d;
            err_q   <= err_d;
        end
    end

    assign mem_req_o   = any_req;
    assign m0_gnt_o    = gnt0;
    assign m1_gnt_o    = gnt1;
    assign m0_rvalid_o = pend_q & ~owner_q;
    assign m1_rvalid_o = pend_q & owner_q;
    assign m0_rdata_o  = rdata_q;
    assign m1_rdata_o  = rdata_q;
    assign stall_cnt_o = stall_q;
    assign proto_err_o = err_q;

endmodule
